fetch_pc_gen: RTL and testbench

- Fetch-stage next-PC generator, directly upstream of the branch-prediction unit.
- Owns the architectural fetch PC and drives the I-cache request handshake.
- Supplies the BPU lookup address and the fetch-accepted strobe, and consumes the BPU's registered prediction and the execute-stage mispredict correction.
- Enforces MIPS delay-slot ordering: after a taken branch, the delay slot is always fetched before the redirect target.

---
 rtl/fetch_pc_gen_pkg.sv | 33 +++
 rtl/fetch_pc_gen_if.sv | 49 ++++
 rtl/fetch_pc_gen.sv | 115 +++++++++++
 tb/tb_fetch_pc_gen.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pc_gen_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pc_gen_pkg
//   Types and constants for the fetch-stage next-PC generator:
//     VIRT_W           virtual address width
//     virt_t           virtual address type
//     RESET_PC_DEFAULT fetch address after reset
//     fetch_state_t    fetch FSM state encoding
//     pc_inc()         sequential next fetch address (wraps modulo 2^VIRT_W)
// ---------------------------------------------------------------------------
package fetch_pc_gen_pkg;

  localparam int VIRT_W = 32;

  typedef logic [VIRT_W-1:0] virt_t;

  localparam virt_t RESET_PC_DEFAULT = 32'hBFC0_0000;

  // RUN      : sequential / predicted fetch
  // DS_WAIT  : predicted-taken branch, delay slot not yet accepted
  // CORR_DS  : mispredict recovery, fetching the branch delay slot
  // CORR_TGT : mispredict recovery, fetching the corrected target
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DS_WAIT  = 2'd1,
    CORR_DS  = 2'd2,
    CORR_TGT = 2'd3
  } fetch_state_t;

  function automatic virt_t pc_inc(input virt_t pc);
    return pc + virt_t'(4);
  endfunction

endpackage

// File: rtl/fetch_pc_gen_if.sv
// ---------------------------------------------------------------------------
// fetch_pc_gen_if
//   Bundles the fetch PC generator's I-cache request, BPU and redirect
//   signals.
//     master : the PC generator (drives req_valid, req_pc, br_valid,
//              corr_finish)
//     slave  : the surrounding I-cache / BPU / execute logic
// ---------------------------------------------------------------------------
interface fetch_pc_gen_if #(
  parameter int PC_W = 32
);

  // I-cache request
  logic            req_valid;
  logic            req_ready;
  logic [PC_W-1:0] req_pc;

  // BPU side
  logic            br_valid;
  logic            pred_valid;
  logic            pred_taken;
  logic [PC_W-1:0] pred_target;

  // Mispredict correction
  logic            corr_valid;
  logic            corr_need_ds;
  logic [PC_W-1:0] corr_ds_pc;
  logic [PC_W-1:0] corr_target;
  logic            corr_finish;

  // Exception / eret redirect
  logic            exc_valid;
  logic [PC_W-1:0] exc_target;

  modport master (
    output req_valid, req_pc, br_valid, corr_finish,
    input  req_ready, pred_valid, pred_taken, pred_target,
    input  corr_valid, corr_need_ds, corr_ds_pc, corr_target,
    input  exc_valid, exc_target
  );

  modport slave (
    input  req_valid, req_pc, br_valid, corr_finish,
    output req_ready, pred_valid, pred_taken, pred_target,
    output corr_valid, corr_need_ds, corr_ds_pc, corr_target,
    output exc_valid, exc_target
  );

endinterface

// File: rtl/fetch_pc_gen.sv
// ---------------------------------------------------------------------------
// fetch_pc_gen
//   Fetch-stage next-PC generator. Owns the fetch PC, issues I-cache
//   requests, feeds the BPU lookup address and fetch-accepted strobe, and
//   applies predictions, mispredict corrections and exception redirects
//   while preserving MIPS delay-slot ordering.
//   Ports:
//     clk   : clock
//     reset : synchronous, active-high reset
//     bus   : fetch_pc_gen_if.master (request, BPU, correction, exception)
// ---------------------------------------------------------------------------
module fetch_pc_gen
  import fetch_pc_gen_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          PC_W     = VIRT_W
) (
  input  logic           clk,
  input  logic           reset,
  fetch_pc_gen_if.master bus
);

  fetch_state_t    state_reg, state_next;
  logic [PC_W-1:0] pc_reg, pc_next;
  logic [PC_W-1:0] pend_reg, pend_next;
  logic            req_valid_reg;
  logic            accept;

  assign accept          = req_valid_reg & bus.req_ready;
  assign bus.req_valid   = req_valid_reg;
  assign bus.req_pc      = pc_reg;
  assign bus.br_valid    = accept;
  // Driven only from registered state and the handshake, so a corr_valid
  // pulse can never ripple through to corr_finish in the same cycle. An
  // exception redirect in the final correction cycle cancels the finish.
  assign bus.corr_finish = (state_reg == CORR_TGT) & accept & ~bus.exc_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= RUN;
      pc_reg        <= PC_W'(RESET_PC);
      pend_reg      <= '0;
      req_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      pend_reg      <= pend_next;
      req_valid_reg <= 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    pend_next  = pend_reg;

    if (bus.exc_valid) begin
      // Exception/eret wins over everything and clears any pending target.
      pc_next    = bus.exc_target;
      pend_next  = '0;
      state_next = RUN;
    end else if (bus.corr_valid &&
                 (state_reg == RUN || state_reg == DS_WAIT)) begin
      // Correction discards any un-accepted request and pending prediction;
      // an address accepted this same cycle still counts as fetched.
      if (bus.corr_need_ds) begin
        pc_next    = bus.corr_ds_pc;
        pend_next  = bus.corr_target;
        state_next = CORR_DS;
      end else begin
        pc_next    = bus.corr_target;
        state_next = CORR_TGT;
      end
    end else begin
      unique case (state_reg)
        RUN: begin
          if (bus.pred_valid && bus.pred_taken) begin
            // The current request is the branch's delay slot; the target
            // may only follow once the delay slot is accepted.
            if (accept) begin
              pc_next = bus.pred_target;
            end else begin
              pend_next  = bus.pred_target;
              state_next = DS_WAIT;
            end
          end else if (accept) begin
            pc_next = PC_W'(pc_reg + PC_W'(4));
          end
        end
        DS_WAIT: begin
          if (accept) begin
            pc_next    = pend_reg;
            state_next = RUN;
          end
        end
        CORR_DS: begin
          if (accept) begin
            pc_next    = pend_reg;
            state_next = CORR_TGT;
          end
        end
        CORR_TGT: begin
          if (accept) begin
            pc_next    = PC_W'(pc_reg + PC_W'(4));
            state_next = RUN;
          end
        end
        default: begin
          state_next = RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// ---------------------------------------------------------------------------
// tb_fetch_pc_gen
//   Directed bench for fetch_pc_gen. Inputs change on the falling edge;
//   outputs are sampled 1 time unit later, and registered state advances on
//   the following rising edge.
// ---------------------------------------------------------------------------
module tb_fetch_pc_gen;
  import fetch_pc_gen_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  fetch_pc_gen_if #(.PC_W(32)) bus ();

  fetch_pc_gen #(
    .RESET_PC (32'hBFC0_0000),
    .PC_W     (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input fetch_state_t exp);
    chk(tag, 32'(dut.state_reg), 32'(exp));
  endtask

  // Wait for the next falling edge (inputs are then updated by the caller).
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.pred_valid   = 1'b0;
    bus.pred_taken   = 1'b0;
    bus.pred_target  = '0;
    bus.corr_valid   = 1'b0;
    bus.corr_need_ds = 1'b0;
    bus.corr_ds_pc   = '0;
    bus.corr_target  = '0;
    bus.exc_valid    = 1'b0;
    bus.exc_target   = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    bus.req_ready = 1'b1;
    clear_inputs();

    // ---------------- reset state ----------------
    next_cycle(); next_cycle(); #1;
    chk("rst_req_valid", 32'(bus.req_valid), 32'd0);
    chk("rst_br_valid", 32'(bus.br_valid), 32'd0);
    chk("rst_corr_finish", 32'(bus.corr_finish), 32'd0);
    chk("rst_req_pc", bus.req_pc, 32'hBFC0_0000);
    chk_state("rst_state", RUN);

    next_cycle(); reset = 1'b0;

    // ---------------- sequential fetch ----------------
    next_cycle(); #1;
    chk("seq0_pc", bus.req_pc, 32'hBFC0_0000);
    chk("seq0_req_valid", 32'(bus.req_valid), 32'd1);
    chk("seq0_br_valid", 32'(bus.br_valid), 32'd1);
    next_cycle(); #1;
    chk("seq1_pc", bus.req_pc, 32'hBFC0_0004);
    chk("seq1_br_valid", 32'(bus.br_valid), 32'd1);
    next_cycle(); #1;
    chk("seq2_pc", bus.req_pc, 32'hBFC0_0008);
    chk("seq2_br_valid", 32'(bus.br_valid), 32'd1);

    // ---------------- taken prediction, no stall ----------------
    next_cycle(); bus.exc_valid = 1'b1; bus.exc_target = 32'h100;
    next_cycle(); clear_inputs(); #1;
    chk("br_pc", bus.req_pc, 32'h100);
    next_cycle();
    bus.pred_valid = 1'b1; bus.pred_taken = 1'b1; bus.pred_target = 32'h200; #1;
    chk("ds_pc", bus.req_pc, 32'h104);
    chk("ds_br_valid", 32'(bus.br_valid), 32'd1);
    next_cycle(); clear_inputs(); #1;
    chk("tgt_pc", bus.req_pc, 32'h200);
    chk_state("tgt_state", RUN);

    // ---------------- taken prediction, delay-slot stall ----------------
    next_cycle(); bus.exc_valid = 1'b1; bus.exc_target = 32'h100;
    next_cycle(); clear_inputs(); #1;
    chk("br2_pc", bus.req_pc, 32'h100);
    next_cycle();
    bus.pred_valid = 1'b1; bus.pred_taken = 1'b1; bus.pred_target = 32'h200;
    bus.req_ready = 1'b0; #1;
    chk("stall0_pc", bus.req_pc, 32'h104);
    chk("stall0_br_valid", 32'(bus.br_valid), 32'd0);
    // A prediction arriving in DS_WAIT must be ignored.
    next_cycle(); bus.pred_target = 32'h999; #1;
    chk("stall1_pc", bus.req_pc, 32'h104);
    chk_state("stall1_state", DS_WAIT);
    next_cycle(); clear_inputs(); #1;
    chk("stall2_pc", bus.req_pc, 32'h104);
    chk_state("stall2_state", DS_WAIT);
    next_cycle(); bus.req_ready = 1'b1; #1;
    chk("stall3_pc", bus.req_pc, 32'h104);
    chk("stall3_br_valid", 32'(bus.br_valid), 32'd1);
    next_cycle(); #1;
    chk("stall_tgt_pc", bus.req_pc, 32'h200);
    chk_state("stall_tgt_state", RUN);

    // ---------------- correction with delay slot ----------------
    next_cycle();
    bus.corr_valid = 1'b1; bus.corr_need_ds = 1'b1;
    bus.corr_ds_pc = 32'h304; bus.corr_target = 32'h400; #1;
    chk("corr_cf0", 32'(bus.corr_finish), 32'd0);
    next_cycle(); clear_inputs(); #1;
    chk("corr_ds_pc", bus.req_pc, 32'h304);
    chk_state("corr_ds_state", CORR_DS);
    chk("corr_cf1", 32'(bus.corr_finish), 32'd0);
    next_cycle(); #1;
    chk("corr_tgt_pc", bus.req_pc, 32'h400);
    chk("corr_cf2", 32'(bus.corr_finish), 32'd1);
    next_cycle(); #1;
    chk("corr_after_pc", bus.req_pc, 32'h404);
    chk("corr_cf3", 32'(bus.corr_finish), 32'd0);
    chk_state("corr_after_state", RUN);

    // ---------------- correction without delay slot, stalled ----------------
    // Coincident taken prediction is dropped; stalled request abandoned.
    bus.corr_valid = 1'b1; bus.corr_need_ds = 1'b0; bus.corr_target = 32'h500;
    bus.pred_valid = 1'b1; bus.pred_taken = 1'b1; bus.pred_target = 32'h600;
    bus.req_ready = 1'b0;
    // A correction arriving while in CORR_TGT must be ignored.
    next_cycle(); clear_inputs();
    bus.corr_valid = 1'b1; bus.corr_target = 32'h700; #1;
    chk("nods_pc", bus.req_pc, 32'h500);
    chk_state("nods_state", CORR_TGT);
    chk("nods_cf0", 32'(bus.corr_finish), 32'd0);
    next_cycle(); clear_inputs(); bus.req_ready = 1'b1; #1;
    chk("nods_hold_pc", bus.req_pc, 32'h500);
    chk("nods_cf1", 32'(bus.corr_finish), 32'd1);
    next_cycle(); #1;
    chk("nods_after_pc", bus.req_pc, 32'h504);
    chk("nods_cf2", 32'(bus.corr_finish), 32'd0);

    // ---------------- priority: exc > corr > pred ----------------
    bus.exc_valid = 1'b1; bus.exc_target = 32'h8000_0180;
    bus.corr_valid = 1'b1; bus.corr_need_ds = 1'b1;
    bus.corr_ds_pc = 32'h904; bus.corr_target = 32'hA00;
    bus.pred_valid = 1'b1; bus.pred_taken = 1'b1; bus.pred_target = 32'hB00;
    #1;
    chk("prio_cf0", 32'(bus.corr_finish), 32'd0);
    next_cycle(); clear_inputs(); #1;
    chk("prio_pc", bus.req_pc, 32'h8000_0180);
    chk_state("prio_state", RUN);
    chk("prio_cf1", 32'(bus.corr_finish), 32'd0);
    next_cycle(); #1;
    chk("prio_next_pc", bus.req_pc, 32'h8000_0184);
    chk("prio_cf2", 32'(bus.corr_finish), 32'd0);

    // ---------------- pc+4 wrap ----------------
    next_cycle(); bus.exc_valid = 1'b1; bus.exc_target = 32'hFFFF_FFFC;
    next_cycle(); clear_inputs(); #1;
    chk("wrap0_pc", bus.req_pc, 32'hFFFF_FFFC);
    next_cycle(); #1;
    chk("wrap1_pc", bus.req_pc, 32'h0000_0000);

    // ---------------- reset mid-correction ----------------
    next_cycle();
    bus.corr_valid = 1'b1; bus.corr_need_ds = 1'b1;
    bus.corr_ds_pc = 32'h304; bus.corr_target = 32'h400;
    next_cycle(); clear_inputs(); bus.req_ready = 1'b0; #1;
    chk("mid_ds_pc", bus.req_pc, 32'h304);
    chk_state("mid_ds_state", CORR_DS);
    reset = 1'b1;
    next_cycle(); reset = 1'b0; bus.req_ready = 1'b1; #1;
    chk("mid_rst_req_valid", 32'(bus.req_valid), 32'd0);
    chk("mid_rst_pc", bus.req_pc, 32'hBFC0_0000);
    chk_state("mid_rst_state", RUN);
    next_cycle(); #1;
    chk("mid_run_req_valid", 32'(bus.req_valid), 32'd1);
    chk("mid_run_pc", bus.req_pc, 32'hBFC0_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
